// File: rtl/uart_defs.sv
// Shared UART definitions: parity encodings and frame state encodings.
// Used by both the transmit and receive sides.
package uart_defs;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: pulses tick on the last clock of each bit period.
// Held at zero while disabled so every frame starts on a fresh period.
module baud_gen #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (en && !tick) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, idle-high NRZ frame out.
// tx and ready are registered; busy is the inverse of ready.
module uart_tx
  import uart_defs::*;
#(
  parameter int N_BITS       = 8,
  parameter int CLKS_PER_BIT = 1250,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  localparam int BW = $clog2(N_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(N_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_t            state_q, state_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              tick;

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid) begin
          shift_d = data;
          par_d   = (^data) ^ (PARITY == PAR_ODD);
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is derived from the next state so tx is a pure flop output.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == ST_IDLE);
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = ~ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx across four frame configurations.
// Expected line levels come from a frame-bit model of the serial format.
module tb_uart_tx;

  localparam int C = 4;
  localparam int NB [4] = '{8, 8, 8, 5};
  localparam int PB [4] = '{0, 1, 2, 0};
  localparam int SB [4] = '{1, 1, 1, 2};

  logic        clk;
  logic        rst;
  logic [3:0]  vld;
  logic [15:0] dat [4];
  logic [3:0]  tx_w, rdy_w, bsy_w;

  int n_chk;
  int n_fail;

  uart_tx #(.N_BITS(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1))
  u_dut0 (.clk(clk), .rst(rst), .data(dat[0][7:0]), .valid(vld[0]),
          .ready(rdy_w[0]), .tx(tx_w[0]), .busy(bsy_w[0]));

  uart_tx #(.N_BITS(8), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1))
  u_dut1 (.clk(clk), .rst(rst), .data(dat[1][7:0]), .valid(vld[1]),
          .ready(rdy_w[1]), .tx(tx_w[1]), .busy(bsy_w[1]));

  uart_tx #(.N_BITS(8), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1))
  u_dut2 (.clk(clk), .rst(rst), .data(dat[2][7:0]), .valid(vld[2]),
          .ready(rdy_w[2]), .tx(tx_w[2]), .busy(bsy_w[2]));

  uart_tx #(.N_BITS(5), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(2))
  u_dut3 (.clk(clk), .rst(rst), .data(dat[3][4:0]), .valid(vld[3]),
          .ready(rdy_w[3]), .tx(tx_w[3]), .busy(bsy_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int flen(input int idx);
    return 1 + NB[idx] + ((PB[idx] != 0) ? 1 : 0) + SB[idx];
  endfunction

  // Level of bit period p (0 = start) of a frame carrying word w.
  function automatic int fbit(input int idx, input logic [15:0] w,
                              input int p);
    int ones;
    int q;
    if (p == 0) return 0;
    if (p <= NB[idx]) return int'(w[p-1]);
    q = p - 1 - NB[idx];
    if (PB[idx] != 0 && q == 0) begin
      ones = 0;
      for (int i = 0; i < NB[idx]; i++) ones += int'(w[i]);
      return (PB[idx] == 1) ? (ones % 2) : 1 - (ones % 2);
    end
    return 1;
  endfunction

  task automatic frame(input int idx, input logic [15:0] w,
                       input logic [15:0] nxt, input bit hold,
                       input bit poke);
    int f;
    int wt;
    f  = flen(idx);
    wt = 0;
    dat[idx] = w;
    vld[idx] = 1'b1;
    while (rdy_w[idx] !== 1'b1 && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    chk("accept_ready", 32'(rdy_w[idx]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    dat[idx] = nxt;
    if (!hold) vld[idx] = 1'b0;
    for (int k = 1; k <= f * C; k++) begin
      if (poke && k == 6) begin
        vld[idx] = 1'b1;
        dat[idx] = 16'h0011;
      end
      if (poke && k == 7) vld[idx] = 1'b0;
      chk("tx_bit", 32'(tx_w[idx]), 32'(fbit(idx, w, (k - 1) / C)));
      chk("ready_low", 32'(rdy_w[idx]), 32'd0);
      chk("busy_high", 32'(bsy_w[idx]), 32'd1);
      @(negedge clk);
    end
    chk("idle_tx", 32'(tx_w[idx]), 32'd1);
    chk("idle_ready", 32'(rdy_w[idx]), 32'd1);
    chk("idle_busy", 32'(bsy_w[idx]), 32'd0);
  endtask

  task automatic mid_reset(input logic [15:0] w);
    dat[0] = w;
    vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (4 * C + 1) @(negedge clk);
    chk("pre_rst_bit3", 32'(tx_w[0]), 32'(w[3]));
    chk("pre_rst_busy", 32'(rdy_w[0]), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx_w[0]), 32'd1);
    chk("async_rst_ready", 32'(rdy_w[0]), 32'd1);
    chk("async_rst_busy", 32'(bsy_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * C) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(tx_w[0]), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] w;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    vld    = '0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_tx", 32'(tx_w[i]), 32'd1);
      chk("reset_ready", 32'(rdy_w[i]), 32'd1);
      chk("reset_busy", 32'(bsy_w[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    frame(0, 16'h00A5, 16'h005A, 1'b0, 1'b0);
    frame(1, 16'h0007, 16'h00F0, 1'b0, 1'b0);
    frame(2, 16'h0007, 16'h00F0, 1'b0, 1'b0);
    frame(3, 16'h001F, 16'h0000, 1'b0, 1'b0);

    frame(0, 16'h0000, 16'h00FF, 1'b1, 1'b0);
    frame(0, 16'h00FF, 16'(($urandom)), 1'b0, 1'b0);

    frame(0, 16'h0042, 16'h0099, 1'b0, 1'b1);
    repeat (3 * C) begin
      chk("no_queued_tx", 32'(tx_w[0]), 32'd1);
      chk("no_queued_ready", 32'(rdy_w[0]), 32'd1);
      @(negedge clk);
    end

    mid_reset(16'h00B6);
    frame(0, 16'h003C, 16'h00C3, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 5; r++) begin
        w = 16'($urandom) & 16'((1 << NB[i]) - 1);
        frame(i, w, 16'($urandom), r[0], 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      vld[i] = 1'b0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
